// File: rtl/gb_rom_arb_pkg.sv
// Shared types and defaults for the multi-port Game Boy ROM arbiter.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package gb_rom_arb_pkg;

  localparam int DEF_NUM_PORTS = 2;
  localparam int DEF_ADDR_W    = 24;
  localparam int DEF_DATA_W    = 16;
  localparam int DEF_MEM_LAT   = 2;

  // Port ids are carried at a fixed width so the pipeline entry type is
  // parameter-independent; 3 bits covers the maximum of 8 ports.
  localparam int PID_W = 3;

  // Width needed to index n items, never less than 1.
  function automatic int clog2(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

  typedef struct packed {
    logic             vld;
    logic [PID_W-1:0] pid;
  } pipe_ent_t;

endpackage

// File: rtl/gb_rr_arbiter.sv
// Round-robin one-hot grant over NUM_PORTS requesters; search starts after the last winner.
// Latency: combinational grant; pointer advances on the clock edge of an enabled grant.
// Backpressure: i_en low suppresses the grant and freezes the pointer.
module gb_rr_arbiter
  import gb_rom_arb_pkg::*;
#(
  parameter int NUM_PORTS = DEF_NUM_PORTS
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic [NUM_PORTS-1:0] i_req,
  input  logic                 i_en,
  output logic [NUM_PORTS-1:0] o_gnt,
  output logic [PID_W-1:0]     o_gnt_id,
  output logic                 o_any
);

  localparam int IDW = clog2(NUM_PORTS);

  logic [IDW-1:0] r_ptr;
  logic           w_found;
  int             w_win;
  int             w_idx;

  // Scan from the pointer, wrapping, and take the first requester.
  always_comb begin
    o_gnt   = '0;
    w_found = 1'b0;
    w_win   = 0;
    w_idx   = 0;
    for (int off = 0; off < NUM_PORTS; off++) begin
      w_idx = (int'(r_ptr) + off) % NUM_PORTS;
      if (!w_found && i_req[w_idx]) begin
        w_found = 1'b1;
        w_win   = w_idx;
      end
    end
    o_any = w_found & i_en;
    if (o_any) o_gnt[w_win] = 1'b1;
    o_gnt_id = PID_W'(w_win);
  end

  // Pointer moves to the port after the winner only when a grant is taken.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_ptr <= '0;
    end else if (o_any) begin
      r_ptr <= IDW'((w_win + 1) % NUM_PORTS);
    end
  end

endmodule

// File: rtl/gb_rom_arbiter.sv
// Shares one ROM among NUM_PORTS cart read channels plus the HPS download write stream.
// Latency: read issue-to-ack MEM_LAT+1 cycles; download issues 2 cycles after dl_wr.
// Backpressure: requests wait while a write is pending or the port is outstanding; dl_wait flags a buffered write.
// Optional build macro GB_ROM_ARB_HIT_CACHE_EN adds a one-entry per-port hit cache.
module gb_rom_arbiter
  import gb_rom_arb_pkg::*;
#(
  parameter int NUM_PORTS = DEF_NUM_PORTS,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int MEM_LAT   = DEF_MEM_LAT
) (
  input  logic                        clk_sys,
  input  logic                        reset_n,
  input  logic                        dl_wr,
  input  logic [ADDR_W-1:0]           dl_addr,
  input  logic [DATA_W-1:0]           dl_data,
  output logic                        dl_wait,
  input  logic [NUM_PORTS-1:0]        rd_req,
  input  logic [NUM_PORTS*ADDR_W-1:0] rd_addr,
  output logic [NUM_PORTS-1:0]        rd_ack,
  output logic [NUM_PORTS*DATA_W-1:0] rd_data,
  output logic [ADDR_W-1:0]           mem_addr,
  output logic                        mem_we,
  output logic [DATA_W-1:0]           mem_din,
  output logic                        mem_rd,
  input  logic [DATA_W-1:0]           mem_dout
);

  logic                        r_dl_full;
  logic [ADDR_W-1:0]           r_dl_addr;
  logic [DATA_W-1:0]           r_dl_data;
  logic                        r_mem_we;
  logic                        r_mem_rd;
  logic [ADDR_W-1:0]           r_mem_addr;
  logic [DATA_W-1:0]           r_mem_din;
  logic [PID_W-1:0]            r_iss_pid;
  pipe_ent_t                   r_pipe [MEM_LAT];
  logic [NUM_PORTS-1:0]        r_out;
  logic [NUM_PORTS-1:0]        r_ack;
  logic [NUM_PORTS*DATA_W-1:0] r_rd_data;

  logic                        w_wr_pend;
  logic                        w_any;
  logic [NUM_PORTS-1:0]        w_gnt;
  logic [NUM_PORTS-1:0]        w_ret;
  logic [NUM_PORTS-1:0]        w_hit;
  logic [NUM_PORTS-1:0]        w_arb_req;
  logic [PID_W-1:0]            w_gnt_id;
  logic [ADDR_W-1:0]           w_gnt_addr;
  pipe_ent_t                   w_exit;

  assign dl_wait  = r_dl_full;
  assign mem_we   = r_mem_we;
  assign mem_rd   = r_mem_rd;
  assign mem_addr = r_mem_addr;
  assign mem_din  = r_mem_din;
  assign rd_ack   = r_ack;
  assign rd_data  = r_rd_data;

  // A write seen this cycle or already buffered blocks every read issue.
  assign w_wr_pend = dl_wr | r_dl_full;
  assign w_exit    = r_pipe[MEM_LAT-1];
  assign w_arb_req = rd_req & ~r_out & ~w_hit;

  gb_rr_arbiter #(
    .NUM_PORTS (NUM_PORTS)
  ) u_rr (
    .i_clk    (clk_sys),
    .i_rst_n  (reset_n),
    .i_req    (w_arb_req),
    .i_en     (~w_wr_pend),
    .o_gnt    (w_gnt),
    .o_gnt_id (w_gnt_id),
    .o_any    (w_any)
  );

  // Winner address mux and one-hot decode of the pipeline exit port.
  always_comb begin
    w_gnt_addr = '0;
    w_ret      = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (w_gnt[p]) w_gnt_addr = rd_addr[p*ADDR_W +: ADDR_W];
      w_ret[p] = w_exit.vld && (w_exit.pid == PID_W'(p));
    end
  end

  // Download buffer and memory command: a new dl_wr overwrites the buffer, else a full buffer issues, else a read grant issues.
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      r_dl_full  <= 1'b0;
      r_dl_addr  <= '0;
      r_dl_data  <= '0;
      r_mem_we   <= 1'b0;
      r_mem_rd   <= 1'b0;
      r_mem_addr <= '0;
      r_mem_din  <= '0;
      r_iss_pid  <= '0;
    end else begin
      r_mem_we <= 1'b0;
      r_mem_rd <= 1'b0;
      if (dl_wr) begin
        r_dl_full <= 1'b1;
        r_dl_addr <= dl_addr;
        r_dl_data <= dl_data;
      end else if (r_dl_full) begin
        r_dl_full  <= 1'b0;
        r_mem_we   <= 1'b1;
        r_mem_addr <= r_dl_addr;
        r_mem_din  <= r_dl_data;
      end else if (w_any) begin
        r_mem_rd   <= 1'b1;
        r_mem_addr <= w_gnt_addr;
        r_iss_pid  <= w_gnt_id;
      end
    end
  end

  // Return pipeline entered the cycle after mem_rd so its exit lines up with mem_dout.
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      for (int k = 0; k < MEM_LAT; k++) r_pipe[k] <= '0;
    end else begin
      r_pipe[0] <= '{vld: r_mem_rd, pid: r_iss_pid};
      for (int k = 1; k < MEM_LAT; k++) r_pipe[k] <= r_pipe[k-1];
    end
  end

  // Outstanding flags: set on grant, cleared as the ack is raised so the ack cycle may carry a new request.
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      r_out <= '0;
    end else begin
      r_out <= (r_out & ~w_ret) | w_gnt;
    end
  end

`ifdef GB_ROM_ARB_HIT_CACHE_EN
  logic [NUM_PORTS-1:0] r_tag_vld;
  logic [NUM_PORTS-1:0] r_nofill;
  logic [ADDR_W-1:0]    r_tag   [NUM_PORTS];
  logic [ADDR_W-1:0]    r_gaddr [NUM_PORTS];
  logic [DATA_W-1:0]    r_cdat  [NUM_PORTS];
  logic                 w_wr_issue;

  assign w_wr_issue = r_dl_full & ~dl_wr;

  // Hit when an idle requesting port matches its tag; held off while a write is pending.
  always_comb begin
    w_hit = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      w_hit[p] = rd_req[p] & ~r_out[p] & r_tag_vld[p] & ~w_wr_pend &
                 (rd_addr[p*ADDR_W +: ADDR_W] == r_tag[p]);
    end
  end

  // Tag valid bits; a read in flight across a write must not refill with pre-write data.
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      r_tag_vld <= '0;
      r_nofill  <= '0;
    end else begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (w_gnt[p]) r_nofill[p] <= 1'b0;
        else if (w_wr_issue && r_out[p]) r_nofill[p] <= 1'b1;
        if (w_wr_issue) r_tag_vld[p] <= 1'b0;
        else if (w_ret[p] && !r_nofill[p]) r_tag_vld[p] <= 1'b1;
      end
    end
  end

  // Cache payload: address captured at grant, word captured on memory return.
  always_ff @(posedge clk_sys) begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (w_gnt[p]) r_gaddr[p] <= w_gnt_addr;
      if (w_ret[p] && !r_nofill[p]) begin
        r_tag[p]  <= r_gaddr[p];
        r_cdat[p] <= mem_dout;
      end
    end
  end
`else
  assign w_hit = '0;
`endif

  // Ack and data return: memory data on pipeline exit, cached data on a hit.
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      r_ack     <= '0;
      r_rd_data <= '0;
    end else begin
      r_ack <= w_ret | w_hit;
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (w_ret[p]) r_rd_data[p*DATA_W +: DATA_W] <= mem_dout;
`ifdef GB_ROM_ARB_HIT_CACHE_EN
        else if (w_hit[p]) r_rd_data[p*DATA_W +: DATA_W] <= r_cdat[p];
`endif
      end
    end
  end

endmodule
